// File: rtl/alu_sequencer.sv
// alu_sequencer: issue/capture controller in front of the 16-bit ALU.
// Takes one operation at a time, holds ctrl/a/b stable while the ALU
// settles, captures result and flags, maintains SREG with per-opcode
// update masks and evaluates branch conditions from SREG.

package constants;
    localparam logic [3:0] ALU_OP_ADD = 4'h0;
    localparam logic [3:0] ALU_OP_SUB = 4'h1;
    localparam logic [3:0] ALU_OP_AND = 4'h2;
    localparam logic [3:0] ALU_OP_OR  = 4'h3;
    localparam logic [3:0] ALU_OP_XOR = 4'h4;
    localparam logic [3:0] ALU_OP_NOR = 4'h5;
    localparam logic [3:0] ALU_OP_SLL = 4'h6;
    localparam logic [3:0] ALU_OP_SRL = 4'h7;
    localparam logic [3:0] ALU_OP_ROL = 4'h8;
    localparam logic [3:0] ALU_OP_SWP = 4'h9;
    localparam logic [3:0] ALU_OP_MUL = 4'hA;
    localparam logic [3:0] ALU_OP_RSV = 4'hF;
endpackage

module alu_sequencer (
    input  logic        clk,
    input  logic        resetn,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [3:0]  req_op,
    input  logic [15:0] req_a,
    input  logic [15:0] req_b,
    input  logic        req_setf,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [15:0] rsp_y,
    output logic [4:0]  rsp_flags,
    output logic [3:0]  alu_ctrl,
    output logic [15:0] alu_a,
    output logic [15:0] alu_b,
    input  logic [15:0] alu_y,
    input  logic        alu_c,
    input  logic        alu_z,
    input  logic        alu_n,
    input  logic        alu_v,
    input  logic        alu_s,
    output logic [4:0]  sreg,
    input  logic        sreg_we,
    input  logic [4:0]  sreg_wdata,
    input  logic [2:0]  cond_sel,
    output logic        cond_true
);
    import constants::*;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_EXEC = 2'd1;
    localparam logic [1:0] ST_CAPT = 2'd2;
    localparam logic [1:0] ST_RESP = 2'd3;

    // Bit positions inside the {S,V,N,Z,C} flag vectors.
    localparam int FLAG_C = 0;
    localparam int FLAG_Z = 1;
    localparam int FLAG_N = 2;
    localparam int FLAG_V = 3;
    localparam int FLAG_S = 4;

    logic [1:0]  state_q,     state_d;
    logic [3:0]  op_q,        op_d;
    logic [15:0] a_q,         a_d;
    logic [15:0] b_q,         b_d;
    logic        setf_q,      setf_d;
    logic [15:0] rsp_y_q,     rsp_y_d;
    logic [4:0]  rsp_flags_q, rsp_flags_d;
    logic [4:0]  sreg_q,      sreg_d;
    logic [4:0]  flags_new;

    // Apply the per-opcode mask: MUL leaves C/V architectural and rebuilds S.
    always_comb begin
        if (op_q == ALU_OP_MUL) begin
            flags_new         = 5'b0;
            flags_new[FLAG_C] = sreg_q[FLAG_C];
            flags_new[FLAG_Z] = alu_z;
            flags_new[FLAG_N] = alu_n;
            flags_new[FLAG_V] = sreg_q[FLAG_V];
            flags_new[FLAG_S] = alu_n ^ sreg_q[FLAG_V];
        end else begin
            flags_new = {alu_s, alu_v, alu_n, alu_z, alu_c};
        end
    end

    // Sequencer next-state and register updates.
    always_comb begin
        // NOTE: every signal gets a hold default first so no path leaves it unassigned, which would infer a latch.
        state_d     = state_q;
        op_d        = op_q;
        a_d         = a_q;
        b_d         = b_q;
        setf_d      = setf_q;
        rsp_y_d     = rsp_y_q;
        rsp_flags_d = rsp_flags_q;
        sreg_d      = sreg_q;
        case (state_q)
            ST_IDLE: begin
                if (sreg_we) begin
                    sreg_d = sreg_wdata;
                end
                if (req_valid) begin
                    op_d    = req_op;
                    a_d     = req_a;
                    b_d     = req_b;
                    setf_d  = req_setf;
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                state_d = ST_CAPT;
            end
            ST_CAPT: begin
                rsp_y_d     = alu_y;
                rsp_flags_d = flags_new;
                if (setf_q) begin
                    sreg_d = flags_new;
                end
                state_d = ST_RESP;
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset discards any in-flight op.
    always_ff @(posedge clk or negedge resetn) begin
        // NOTE: every register here, datapath included, has a defined reset value because reset must visibly clear the outputs.
        if (!resetn) begin
            state_q     <= ST_IDLE;
            op_q        <= 4'h0;
            a_q         <= 16'h0000;
            b_q         <= 16'h0000;
            setf_q      <= 1'b0;
            rsp_y_q     <= 16'h0000;
            rsp_flags_q <= 5'b0;
            sreg_q      <= 5'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the pre-edge values of the others.
            state_q     <= state_d;
            op_q        <= op_d;
            a_q         <= a_d;
            b_q         <= b_d;
            setf_q      <= setf_d;
            rsp_y_q     <= rsp_y_d;
            rsp_flags_q <= rsp_flags_d;
            sreg_q      <= sreg_d;
        end
    end

    // Branch condition decode from architectural SREG.
    always_comb begin
        cond_true = 1'b1;
        case (cond_sel)
            3'd0: cond_true = 1'b1;
            3'd1: cond_true = sreg_q[FLAG_Z];
            3'd2: cond_true = ~sreg_q[FLAG_Z];
            3'd3: cond_true = sreg_q[FLAG_C];
            3'd4: cond_true = ~sreg_q[FLAG_C];
            3'd5: cond_true = sreg_q[FLAG_N];
            3'd6: cond_true = sreg_q[FLAG_S];
            3'd7: cond_true = ~sreg_q[FLAG_S];
            default: cond_true = 1'b1;
        endcase
    end

    assign req_ready = (state_q == ST_IDLE);
    assign rsp_valid = (state_q == ST_RESP);
    assign rsp_y     = rsp_y_q;
    assign rsp_flags = rsp_flags_q;
    assign alu_ctrl  = op_q;
    assign alu_a     = a_q;
    assign alu_b     = b_q;
    assign sreg      = sreg_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// Self-checking bench for alu_sequencer: a registered ALU stand-in drives
// the alu_* inputs; a transaction-level model tracks SREG and expected
// responses from the opcode, operands and masking rules.
module tb_alu_sequencer;
    import constants::*;

    logic        clk = 1'b0;
    logic        resetn;
    logic        req_valid, req_ready, req_setf;
    logic [3:0]  req_op;
    logic [15:0] req_a, req_b;
    logic        rsp_valid, rsp_ready;
    logic [15:0] rsp_y;
    logic [4:0]  rsp_flags;
    logic [3:0]  alu_ctrl;
    logic [15:0] alu_a, alu_b, alu_y;
    logic        alu_c, alu_z, alu_n, alu_v, alu_s;
    logic [4:0]  sreg;
    logic        sreg_we;
    logic [4:0]  sreg_wdata;
    logic [2:0]  cond_sel;
    logic        cond_true;

    int n_tests = 0;
    int n_fail  = 0;
    logic [4:0] m_sreg;  // model of architectural SREG {S,V,N,Z,C}

    alu_sequencer dut (
        .clk(clk), .resetn(resetn),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_a(req_a), .req_b(req_b), .req_setf(req_setf),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_y(rsp_y), .rsp_flags(rsp_flags),
        .alu_ctrl(alu_ctrl), .alu_a(alu_a), .alu_b(alu_b),
        .alu_y(alu_y), .alu_c(alu_c), .alu_z(alu_z), .alu_n(alu_n),
        .alu_v(alu_v), .alu_s(alu_s),
        .sreg(sreg), .sreg_we(sreg_we), .sreg_wdata(sreg_wdata),
        .cond_sel(cond_sel), .cond_true(cond_true)
    );

    always #5 clk = ~clk;

    // ALU stand-in: returns {S,V,N,Z,C,y}. For non-arithmetic ops C/V are
    // arbitrary operand bits, and for MUL C/V/S are deliberately junk so
    // that the sequencer's masking is observable.
    function automatic logic [20:0] alu_fn(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
        logic [16:0] w;
        logic [15:0] y;
        logic [4:0]  sh;
        logic        c, v, n, z, s;
        c = b[0];
        v = a[0];
        case (op)
            ALU_OP_ADD: begin
                w = {1'b0, a} + {1'b0, b};
                y = w[15:0];
                c = w[16];
                v = (a[15] == b[15]) && (y[15] != a[15]);
            end
            ALU_OP_SUB: begin
                y = a - b;
                c = (a < b);
                v = (a[15] != b[15]) && (y[15] != a[15]);
            end
            ALU_OP_AND: y = a & b;
            ALU_OP_OR:  y = a | b;
            ALU_OP_XOR: y = a ^ b;
            ALU_OP_NOR: y = ~(a | b);
            ALU_OP_SLL: y = a << b[3:0];
            ALU_OP_SRL: y = a >> b[3:0];
            ALU_OP_ROL: begin
                sh = 5'd16 - {1'b0, b[3:0]};
                y  = (a << b[3:0]) | (a >> sh);
            end
            ALU_OP_SWP: y = {a[7:0], a[15:8]};
            ALU_OP_MUL: begin
                y = a * b;
                c = a[1];
                v = b[1];
            end
            default: y = a;
        endcase
        n = y[15];
        z = (y == 16'h0000);
        s = (op == ALU_OP_MUL) ? n : (n ^ v);
        return {s, v, n, z, c, y};
    endfunction

    // Expected flag vector for an op given the SREG it executes against.
    function automatic logic [4:0] ref_flags(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b, input logic [4:0] cur);
        logic [20:0] r;
        logic s, v, n, z, c;
        r = alu_fn(op, a, b);
        {s, v, n, z, c} = r[20:16];
        if (op == ALU_OP_MUL) begin
            c = cur[0];
            v = cur[3];
            s = n ^ cur[3];
        end
        return {s, v, n, z, c};
    endfunction

    function automatic logic cond_ref(input logic [2:0] sel, input logic [4:0] f);
        logic s, v, n, z, c;
        {s, v, n, z, c} = f;
        case (sel)
            3'd0: return 1'b1;
            3'd1: return z;
            3'd2: return !z;
            3'd3: return c;
            3'd4: return !c;
            3'd5: return n;
            3'd6: return s;
            default: return !s;
        endcase
    endfunction

    // Registered ALU: samples ctrl/a/b at each edge, result valid next cycle.
    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            {alu_s, alu_v, alu_n, alu_z, alu_c, alu_y} <= '0;
        end else begin
            {alu_s, alu_v, alu_n, alu_z, alu_c, alu_y} <= alu_fn(alu_ctrl, alu_a, alu_b);
        end
    end

    // Issue one op (optionally with an IDLE SREG write on the accept edge),
    // update the model, and wait for rsp_valid. Leaves the DUT in RESP.
    task automatic do_op(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                         input logic setf, input logic we, input logic [4:0] wdata,
                         output logic [15:0] ey, output logic [4:0] ef, output int lat);
        logic [20:0] r;
        @(negedge clk);
        n_tests++;
        if (req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL req_ready_idle: got %b want 1", req_ready);
        end
        req_op = op; req_a = a; req_b = b; req_setf = setf;
        sreg_we = we; sreg_wdata = wdata; req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0; sreg_we = 1'b0;
        n_tests++;
        if (alu_ctrl !== op || alu_a !== a || alu_b !== b || req_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL alu_drive: got ctrl=%h a=%h b=%h rdy=%b want ctrl=%h a=%h b=%h rdy=0",
                     alu_ctrl, alu_a, alu_b, req_ready, op, a, b);
        end
        if (we) m_sreg = wdata;
        r  = alu_fn(op, a, b);
        ey = r[15:0];
        ef = ref_flags(op, a, b, m_sreg);
        if (setf) m_sreg = ef;
        lat = 1;
        while (rsp_valid !== 1'b1 && lat < 20) begin
            @(negedge clk);
            lat++;
        end
    endtask

    // Hold rsp_ready low for 'hold' cycles checking stability, then handshake.
    task automatic finish_rsp(input int hold, input logic [15:0] ey, input logic [4:0] ef);
        rsp_ready = 1'b0;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            n_tests++;
            if (rsp_valid !== 1'b1 || req_ready !== 1'b0 || rsp_y !== ey || rsp_flags !== ef) begin
                n_fail++;
                $display("FAIL resp_hold: got v=%b rdy=%b y=%h f=%b want v=1 rdy=0 y=%h f=%b",
                         rsp_valid, req_ready, rsp_y, rsp_flags, ey, ef);
            end
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        n_tests++;
        if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL resp_release: got v=%b rdy=%b want v=0 rdy=1", rsp_valid, req_ready);
        end
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        #12;
        n_tests++;
        if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || rsp_y !== 16'h0000 || rsp_flags !== 5'b0 ||
            sreg !== 5'b0 || alu_ctrl !== 4'h0 || alu_a !== 16'h0000 || alu_b !== 16'h0000) begin
            n_fail++;
            $display("FAIL reset_values: rdy=%b v=%b y=%h f=%b sreg=%b ctrl=%h a=%h b=%h want 1 0 0000 0 0 0 0000 0000",
                     req_ready, rsp_valid, rsp_y, rsp_flags, sreg, alu_ctrl, alu_a, alu_b);
        end
        for (int s = 0; s < 8; s++) begin
            cond_sel = 3'(s);
            #1;
            n_tests++;
            if (cond_true !== cond_ref(3'(s), 5'b0)) begin
                n_fail++;
                $display("FAIL reset_cond[%0d]: got %b want %b", s, cond_true, cond_ref(3'(s), 5'b0));
            end
        end
        cond_sel = 3'd0;
        m_sreg = 5'b0;
        @(negedge clk);
        resetn = 1'b1;
    endtask

    task automatic test_add_overflow();
        logic [15:0] ey; logic [4:0] ef; int lat;
        do_op(ALU_OP_ADD, 16'h7FFF, 16'h0001, 1'b1, 1'b0, 5'b0, ey, ef, lat);
        n_tests++;
        if (lat != 3 || rsp_y !== 16'h8000 || rsp_flags !== 5'b01100 || sreg !== 5'b01100) begin
            n_fail++;
            $display("FAIL add_overflow: got lat=%0d y=%h f=%b sreg=%b want lat=3 y=8000 f=01100 sreg=01100",
                     lat, rsp_y, rsp_flags, sreg);
        end
        finish_rsp(0, ey, ef);
    endtask

    task automatic test_sub_cond();
        logic [15:0] ey; logic [4:0] ef; int lat;
        do_op(ALU_OP_SUB, 16'h0000, 16'h0001, 1'b1, 1'b0, 5'b0, ey, ef, lat);
        n_tests++;
        if (lat != 3 || rsp_y !== 16'hFFFF || rsp_flags !== 5'b10101 || sreg !== 5'b10101) begin
            n_fail++;
            $display("FAIL sub_borrow: got lat=%0d y=%h f=%b sreg=%b want lat=3 y=ffff f=10101 sreg=10101",
                     lat, rsp_y, rsp_flags, sreg);
        end
        for (int s = 0; s < 8; s++) begin
            cond_sel = 3'(s);
            #1;
            n_tests++;
            if (cond_true !== cond_ref(3'(s), 5'b10101)) begin
                n_fail++;
                $display("FAIL sub_cond[%0d]: got %b want %b", s, cond_true, cond_ref(3'(s), 5'b10101));
            end
        end
        cond_sel = 3'd0;
        finish_rsp(1, ey, ef);
    endtask

    task automatic test_mul_mask();
        logic [15:0] ey; logic [4:0] ef; int lat;
        do_op(ALU_OP_ADD, 16'h7FFF, 16'h0001, 1'b1, 1'b0, 5'b0, ey, ef, lat);
        finish_rsp(0, ey, ef);
        do_op(ALU_OP_MUL, 16'h0003, 16'hFFFE, 1'b1, 1'b0, 5'b0, ey, ef, lat);
        n_tests++;
        if (lat != 3 || rsp_y !== 16'hFFFA || rsp_flags !== 5'b01100 || sreg !== 5'b01100) begin
            n_fail++;
            $display("FAIL mul_mask: got lat=%0d y=%h f=%b sreg=%b want lat=3 y=fffa f=01100 sreg=01100",
                     lat, rsp_y, rsp_flags, sreg);
        end
        finish_rsp(0, ey, ef);
    endtask

    task automatic test_xor_nosetf();
        logic [15:0] ey; logic [4:0] ef; int lat; logic [4:0] prior;
        prior = m_sreg;
        do_op(ALU_OP_XOR, 16'h1234, 16'h1234, 1'b0, 1'b0, 5'b0, ey, ef, lat);
        n_tests++;
        if (lat != 3 || rsp_y !== 16'h0000 || rsp_flags !== 5'b00010 || sreg !== prior) begin
            n_fail++;
            $display("FAIL xor_nosetf: got lat=%0d y=%h f=%b sreg=%b want lat=3 y=0000 f=00010 sreg=%b",
                     lat, rsp_y, rsp_flags, sreg, prior);
        end
        finish_rsp(0, ey, ef);
    endtask

    task automatic test_back_pressure();
        logic [15:0] ey; logic [4:0] ef; int lat;
        do_op(ALU_OP_ADD, 16'h0102, 16'h0304, 1'b1, 1'b0, 5'b0, ey, ef, lat);
        req_op = ALU_OP_SUB; req_a = 16'hAAAA; req_b = 16'h5555; req_setf = 1'b1;
        req_valid = 1'b1; sreg_we = 1'b1; sreg_wdata = 5'b10101;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            n_tests++;
            if (rsp_valid !== 1'b1 || req_ready !== 1'b0 || rsp_y !== 16'h0406 || rsp_flags !== ef ||
                sreg !== m_sreg || alu_ctrl !== ALU_OP_ADD) begin
                n_fail++;
                $display("FAIL bp_hold[%0d]: got v=%b rdy=%b y=%h f=%b sreg=%b ctrl=%h want 1 0 0406 %b %b %h",
                         i, rsp_valid, req_ready, rsp_y, rsp_flags, sreg, alu_ctrl, ef, m_sreg, ALU_OP_ADD);
            end
        end
        req_valid = 1'b0; sreg_we = 1'b0;
        finish_rsp(0, ey, ef);
        n_tests++;
        if (sreg !== m_sreg) begin
            n_fail++;
            $display("FAIL bp_resp_we_ignored: got sreg=%b want %b", sreg, m_sreg);
        end
        sreg_we = 1'b1; sreg_wdata = 5'b10101;
        @(negedge clk);
        sreg_we = 1'b0;
        m_sreg = 5'b10101;
        n_tests++;
        if (sreg !== 5'b10101 || req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL idle_sreg_write: got sreg=%b rdy=%b want sreg=10101 rdy=1", sreg, req_ready);
        end
    endtask

    task automatic test_reset_midop();
        logic [15:0] ey; logic [4:0] ef; int lat; int seen;
        @(negedge clk);
        req_op = ALU_OP_ADD; req_a = 16'h0001; req_b = 16'h0001; req_setf = 1'b1; req_valid = 1'b1;
        @(negedge clk);           // accepted: EXEC
        req_valid = 1'b0;
        @(negedge clk);           // CAPT
        resetn = 1'b0;
        #1;
        m_sreg = 5'b0;
        n_tests++;
        if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || rsp_y !== 16'h0000 || rsp_flags !== 5'b0 ||
            sreg !== 5'b0 || alu_ctrl !== 4'h0 || alu_a !== 16'h0000 || alu_b !== 16'h0000) begin
            n_fail++;
            $display("FAIL midop_reset: rdy=%b v=%b y=%h f=%b sreg=%b ctrl=%h a=%h b=%h want 1 0 0000 0 0 0 0000 0000",
                     req_ready, rsp_valid, rsp_y, rsp_flags, sreg, alu_ctrl, alu_a, alu_b);
        end
        @(negedge clk);
        resetn = 1'b1;
        seen = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (rsp_valid !== 1'b0) seen++;
        end
        n_tests++;
        if (seen != 0) begin
            n_fail++;
            $display("FAIL midop_no_rsp: got %0d cycles of rsp_valid want 0", seen);
        end
        do_op(ALU_OP_SUB, 16'h0005, 16'h0003, 1'b1, 1'b0, 5'b0, ey, ef, lat);
        n_tests++;
        if (lat != 3 || rsp_y !== 16'h0002 || rsp_flags !== 5'b00000 || sreg !== 5'b00000) begin
            n_fail++;
            $display("FAIL post_reset_sub: got lat=%0d y=%h f=%b sreg=%b want lat=3 y=0002 f=00000 sreg=00000",
                     lat, rsp_y, rsp_flags, sreg);
        end
        finish_rsp(0, ey, ef);
    endtask

    task automatic test_random();
        logic [15:0] ey, a, b; logic [4:0] ef, wd; logic [3:0] op; logic [2:0] sel;
        logic setf, we; int lat;
        for (int i = 0; i < 40; i++) begin
            op   = 4'($urandom_range(0, 15));
            a    = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(0, 4)) : 16'($urandom);
            b    = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(0, 4)) : 16'($urandom);
            setf = 1'($urandom_range(0, 1));
            we   = ($urandom_range(0, 3) == 0);
            wd   = 5'($urandom);
            do_op(op, a, b, setf, we, wd, ey, ef, lat);
            n_tests++;
            if (lat != 3 || rsp_y !== ey || rsp_flags !== ef || sreg !== m_sreg) begin
                n_fail++;
                $display("FAIL rand[%0d] op=%h a=%h b=%h setf=%b we=%b: got lat=%0d y=%h f=%b sreg=%b want lat=3 y=%h f=%b sreg=%b",
                         i, op, a, b, setf, we, lat, rsp_y, rsp_flags, sreg, ey, ef, m_sreg);
            end
            sel = 3'($urandom_range(0, 7));
            cond_sel = sel;
            #1;
            n_tests++;
            if (cond_true !== cond_ref(sel, m_sreg)) begin
                n_fail++;
                $display("FAIL rand_cond[%0d] sel=%0d: got %b want %b", i, sel, cond_true, cond_ref(sel, m_sreg));
            end
            finish_rsp($urandom_range(0, 2), ey, ef);
        end
    endtask

    initial begin
        resetn = 1'b0; req_valid = 1'b0; req_op = 4'h0; req_a = 16'h0; req_b = 16'h0;
        req_setf = 1'b0; rsp_ready = 1'b0; sreg_we = 1'b0; sreg_wdata = 5'b0; cond_sel = 3'd0;
        m_sreg = 5'b0;
        test_reset();
        test_add_overflow();
        test_sub_cond();
        test_mul_mask();
        test_xor_nosetf();
        test_back_pressure();
        test_reset_midop();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
